// File: rtl/subtractor_pkg.sv
// subtractor_pkg: shared state type and default sizing for the chunked subtractor
package subtractor_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  localparam int N_DEF = 32;
  localparam int CHUNK_DEF = 8;
endpackage

// File: rtl/subtractor_32bit_seq_if.sv
// subtractor_32bit_seq_if: request/result handshake bundle for the sequential subtractor
interface subtractor_32bit_seq_if #(parameter int N = subtractor_pkg::N_DEF);
  logic valid_i;
  logic ready_o;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic bin;
  logic valid_o;
  logic ready_i;
  logic [N-1:0] diff;
  logic bout;
  logic ovf;
  modport master (output valid_i, a, b, bin, ready_i, input ready_o, valid_o, diff, bout, ovf);
  modport slave (input valid_i, a, b, bin, ready_i, output ready_o, valid_o, diff, bout, ovf);
endinterface

// File: rtl/sub_chunk.sv
// sub_chunk: combinational W-bit ripple-borrow subtractor built from one-bit full subtractors
module sub_chunk #(
  parameter int W = subtractor_pkg::CHUNK_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);
  logic [W:0] br;
  assign br[0] = bin;
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign diff[i] = a[i] ^ b[i] ^ br[i];
    assign br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end
  assign bout = br[W];
endmodule

// File: rtl/subtractor_32bit_seq.sv
// subtractor_32bit_seq: multi-cycle a - b - bin, one CHUNK-bit slice per clock
module subtractor_32bit_seq
  import subtractor_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input logic clk,
  input logic rst,
  subtractor_32bit_seq_if.slave bus
);
  localparam int NK = N / CHUNK;
  localparam int KW = (NK > 1) ? $clog2(NK) : 1;
  if (N % CHUNK != 0) begin : g_chk
    $error("N must be a multiple of CHUNK");
  end
  state_e state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [KW-1:0] k_q, k_d;
  logic br_q, br_d, bout_q, bout_d, ovf_q, ovf_d;
  logic [CHUNK-1:0] c_diff;
  logic c_bout, last;
  sub_chunk #(.W(CHUNK)) u_chunk (
    .a(a_q[int'(k_q)*CHUNK +: CHUNK]),
    .b(b_q[int'(k_q)*CHUNK +: CHUNK]),
    .bin(br_q),
    .diff(c_diff),
    .bout(c_bout)
  );
  assign last = k_q == KW'(NK - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      diff_q <= '0;
      k_q <= '0;
      br_q <= 1'b0;
      bout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      diff_q <= diff_d;
      k_q <= k_d;
      br_q <= br_d;
      bout_q <= bout_d;
      ovf_q <= ovf_d;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    diff_d = diff_q;
    k_d = k_q;
    br_d = br_q;
    bout_d = bout_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (bus.valid_i) begin
        a_d = bus.a;
        b_d = bus.b;
        br_d = bus.bin;
        k_d = '0;
        state_d = CALC;
      end
      CALC: begin
        diff_d[int'(k_q)*CHUNK +: CHUNK] = c_diff;
        br_d = c_bout;
        k_d = last ? k_q : k_q + 1'b1;
        if (last) begin
          state_d = DONE;
          bout_d = c_bout;
          ovf_d = (a_q[N-1] != b_q[N-1]) && (diff_d[N-1] != a_q[N-1]);
        end
      end
      DONE: state_d = bus.ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.ready_o = state_q == IDLE;
  assign bus.valid_o = state_q == DONE;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf = ovf_q;
endmodule

// File: doc/subtractor_32bit_seq.md
SUBTRACTOR_32BIT_SEQ -- requirements
Module: subtractor_32bit_seq

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, meaning bits processed per cycle; N SHALL be a multiple of CHUNK, checked at elaboration.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 valid_i  input  1  operand request valid.
REQ-006 ready_o  output  1  block accepts a new request.
REQ-007 a  input  N  minuend, unsigned or two's complement.
REQ-008 b  input  N  subtrahend.
REQ-009 bin  input  1  borrow-in.
REQ-010 valid_o  output  1  result valid.
REQ-011 ready_i  input  1  consumer accepts the result.
REQ-012 diff  output  N  result of a - b - bin, modulo 2^N.
REQ-013 bout  output  1  borrow-out: 1 iff unsigned a < b + bin.
REQ-014 ovf  output  1  signed overflow of a - b - bin.

Function
REQ-015 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-016 ready_o SHALL be 1 only in IDLE; valid_o SHALL be 1 only in DONE.
REQ-017 In IDLE, valid_i=1 SHALL capture a, b and bin into internal registers, clear the chunk counter to 0, load the borrow register with bin, and go to CALC; valid_i=0 SHALL keep the block in IDLE.
REQ-018 Each CALC cycle SHALL compute chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) as a_k - b_k - borrow, write it into the diff register, update the borrow register with the chunk borrow, and increment k.
REQ-019 After chunk N/CHUNK-1, the block SHALL go to DONE and set bout to the final borrow.
REQ-020 On that same final CALC edge, ovf SHALL be set to (a[N-1] != b[N-1]) AND (diff[N-1] != a[N-1]).
REQ-021 Latency: valid_o SHALL rise exactly N/CHUNK cycles after the accepting edge (4 cycles for the defaults).
REQ-022 In DONE, diff, bout and ovf SHALL hold stable while valid_o=1 and ready_i=0; there is no timeout.
REQ-023 In DONE, ready_i=1 SHALL return the block to IDLE on that edge, with valid_o low the next cycle.
REQ-024 No back-to-back overlap: a new request is accepted no earlier than the cycle after the result handshake; minimum throughput is one result per N/CHUNK+2 cycles.
REQ-025 Operand inputs SHALL be ignored outside IDLE; changes to them during CALC or DONE SHALL NOT affect the result.
REQ-026 ready_i SHALL be ignored outside DONE.
REQ-027 The counter SHALL use clog2(N/CHUNK) bits, or 1 bit minimum, and SHALL NOT wrap within a single operation.

Reset
REQ-028 Asserting rst SHALL immediately force state to IDLE.
REQ-029 Asserting rst SHALL immediately force ready_o=1, valid_o=0, diff=0, bout=0, ovf=0, the counter to 0 and the borrow register to 0.
REQ-030 Reset asserted during CALC or DONE SHALL abort the operation with no result presented.
REQ-031 The first request after reset release SHALL be accepted on the first rising edge with valid_i=1.

Structure
REQ-032 A shared package subtractor_pkg SHALL hold the state enum type (IDLE/CALC/DONE) and the default constants N=32 and CHUNK=8.
REQ-033 The block SHALL instantiate one combinational sub-module, sub_chunk, CHUNK bits wide (inputs a, b, bin; outputs diff, bout), built as a generate-chained ripple of one-bit full subtractors.

Verification
REQ-034 a=0x0000_0005, b=0x0000_0003, bin=0 -> diff=0x0000_0002, bout=0, ovf=0; valid_o rises 4 cycles after acceptance.
REQ-035 a=0x0000_0000, b=0x0000_0001, bin=0 -> diff=0xFFFF_FFFF, bout=1, ovf=0; this checks the borrow ripple across all chunks.
REQ-036 a=0x8000_0000, b=0x0000_0001, bin=0 -> diff=0x7FFF_FFFF, bout=0, ovf=1; a=0x1234_5678, b=0x1234_5678, bin=1 -> diff=0xFFFF_FFFF, bout=1.
REQ-037 Result backpressure: ready_i held 0 for 10 cycles -> valid_o and diff stable throughout, and ready_o stays 0; ready_i=1 then gives ready_o=1 on the next cycle.
REQ-038 Input isolation: change a and b on every cycle during CALC -> the result matches the operands captured at acceptance.
REQ-039 Reset mid-operation: pulse rst during the 2nd CALC cycle -> all outputs match reset values asynchronously, then a new request 0x10-0x01 returns 0x0F.
